// File: rtl/sap_ctrl_pkg.sv
// Shared SAP control definitions: control-word bit indices, strobe masks,
// opcode values and the default microstep count.
package sap_ctrl_pkg;

  localparam int unsigned NUM_STEPS_DEFAULT = 5;

  localparam int unsigned BIT_HLT = 15;
  localparam int unsigned BIT_MI  = 14;
  localparam int unsigned BIT_RI  = 13;
  localparam int unsigned BIT_RO  = 12;
  localparam int unsigned BIT_IO  = 11;
  localparam int unsigned BIT_II  = 10;
  localparam int unsigned BIT_AI  = 9;
  localparam int unsigned BIT_AO  = 8;
  localparam int unsigned BIT_EO  = 7;
  localparam int unsigned BIT_SU  = 6;
  localparam int unsigned BIT_BI  = 5;
  localparam int unsigned BIT_OI  = 4;
  localparam int unsigned BIT_CE  = 3;
  localparam int unsigned BIT_CO  = 2;
  localparam int unsigned BIT_J   = 1;
  localparam int unsigned BIT_FI  = 0;

  typedef logic [15:0] ctrl_t;

  function automatic ctrl_t bit_mask(input int unsigned idx);
    return ctrl_t'(1) << idx;
  endfunction

  localparam ctrl_t C_HLT = bit_mask(BIT_HLT);
  localparam ctrl_t C_MI  = bit_mask(BIT_MI);
  localparam ctrl_t C_RI  = bit_mask(BIT_RI);
  localparam ctrl_t C_RO  = bit_mask(BIT_RO);
  localparam ctrl_t C_IO  = bit_mask(BIT_IO);
  localparam ctrl_t C_II  = bit_mask(BIT_II);
  localparam ctrl_t C_AI  = bit_mask(BIT_AI);
  localparam ctrl_t C_AO  = bit_mask(BIT_AO);
  localparam ctrl_t C_EO  = bit_mask(BIT_EO);
  localparam ctrl_t C_SU  = bit_mask(BIT_SU);
  localparam ctrl_t C_BI  = bit_mask(BIT_BI);
  localparam ctrl_t C_OI  = bit_mask(BIT_OI);
  localparam ctrl_t C_CE  = bit_mask(BIT_CE);
  localparam ctrl_t C_CO  = bit_mask(BIT_CO);
  localparam ctrl_t C_J   = bit_mask(BIT_J);
  localparam ctrl_t C_FI  = bit_mask(BIT_FI);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic {
    SEQ_RUN,
    SEQ_HALT
  } seq_state_e;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: (step, opcode, flags) -> 16-bit control word.
// Fetch words are opcode-independent; unlisted steps decode to zero.
module microcode_rom
  import sap_ctrl_pkg::*;
(
  input  logic [2:0]  step,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] word
);

  // Operand address from the instruction register onto the memory address register.
  localparam ctrl_t ADDR_LOAD = C_IO | C_MI;

  always_comb begin
    // NOTE: default first so every path assigns word; no latch is inferred.
    word = '0;
    case (step)
      3'd0: word = C_CO | C_MI;
      3'd1: word = C_RO | C_II | C_CE;
      default: begin
        case (opcode)
          OP_LDA: begin
            if (step == 3'd2) word = ADDR_LOAD;
            if (step == 3'd3) word = C_RO | C_AI;
          end
          OP_ADD, OP_SUB: begin
            if (step == 3'd2) word = ADDR_LOAD;
            if (step == 3'd3) word = C_RO | C_BI;
            if (step == 3'd4) word = (opcode == OP_SUB) ? (C_EO | C_AI | C_SU | C_FI)
                                                        : (C_EO | C_AI | C_FI);
          end
          OP_STA: begin
            if (step == 3'd2) word = ADDR_LOAD;
            if (step == 3'd3) word = C_AO | C_RI;
          end
          OP_LDI: if (step == 3'd2) word = C_IO | C_AI;
          OP_JMP: if (step == 3'd2) word = C_IO | C_J;
          OP_JC:  if (step == 3'd2 && flag_c) word = C_IO | C_J;
          OP_JZ:  if (step == 3'd2 && flag_z) word = C_IO | C_J;
          OP_OUT: if (step == 3'd2) word = C_AO | C_OI;
          OP_HLT: if (step == 3'd2) word = C_HLT;
          default: word = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP control sequencer: microstep counter with early end on an all-zero word,
// halt latch, and the control word decoded from the registered step.
module control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STEPS = NUM_STEPS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  seq_state_e  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] rom_word;

  microcode_rom u_rom (
    .step   (step_q),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .word   (rom_word)
  );

  // NOTE: reset is sampled on the clock edge and wins over every other update;
  // state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SEQ_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      SEQ_RUN: begin
        if (rom_word[BIT_HLT]) begin
          // Step stays frozen at the HLT microstep.
          state_d = SEQ_HALT;
        end else if (step_q >= 3'd2 && rom_word == '0) begin
          step_d = '0;
        end else if (step_q == LAST_STEP) begin
          step_d = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
      end
    endcase
  end

  assign halted = (state_q == SEQ_HALT);
  assign step   = step_q;
  assign ctrl   = halted ? C_HLT : rom_word;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a per-cycle stimulus list with
// expected outputs pushed to a scoreboard and compared before each edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  typedef struct {
    logic [3:0]  op;
    logic        fc;
    logic        fz;
    logic        rst;
    logic [2:0]  st;
    logic [15:0] ct;
    logic        h;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] ct;
    logic        h;
  } exp_t;

  vec_t stim_q[$];
  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  control_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ctrl),
    .step   (step),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic fc, input logic fz, input logic rst,
                     input logic [2:0] st, input logic [15:0] ct, input logic h);
    vec_t v;
    v.op = op; v.fc = fc; v.fz = fz; v.rst = rst; v.st = st; v.ct = ct; v.h = h;
    stim_q.push_back(v);
  endtask

  // One instruction: fetch (with a different opcode on the bus, which must be
  // ignored) followed by n execute cycles T2.. carrying the given words.
  task automatic instr(input logic [3:0] op, input logic fc, input logic fz, input int n,
                       input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    logic [15:0] w[3];
    w[0] = w2; w[1] = w3; w[2] = w4;
    add(op ^ 4'hA, fc, fz, 1'b1, 3'd0, 16'h4004, 1'b0);
    add(~op,       fc, fz, 1'b1, 3'd1, 16'h1408, 1'b0);
    for (int k = 0; k < n; k++)
      add(op, fc, fz, 1'b1, 3'(2 + k), w[k], 1'b0);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   idx;

    reset = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    @(posedge clk);
    @(negedge clk);

    instr(4'h5, 0, 0, 2, 16'h0A00, 16'h0000, 16'h0000);  // LDI
    instr(4'h2, 0, 0, 3, 16'h4800, 16'h1020, 16'h0281);  // ADD wraps after T4
    instr(4'h3, 0, 0, 3, 16'h4800, 16'h1020, 16'h02C1);  // SUB
    instr(4'h1, 0, 0, 3, 16'h4800, 16'h1200, 16'h0000);  // LDA
    instr(4'h4, 0, 0, 3, 16'h4800, 16'h2100, 16'h0000);  // STA
    instr(4'h6, 0, 0, 2, 16'h0802, 16'h0000, 16'h0000);  // JMP
    instr(4'hE, 0, 0, 2, 16'h0110, 16'h0000, 16'h0000);  // OUT
    instr(4'h7, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000);  // JC untaken
    instr(4'h7, 1, 0, 2, 16'h0802, 16'h0000, 16'h0000);  // JC taken
    instr(4'h8, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000);  // JZ untaken
    instr(4'h8, 0, 1, 2, 16'h0802, 16'h0000, 16'h0000);  // JZ taken
    instr(4'h0, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000);  // NOP
    instr(4'hB, 1, 1, 1, 16'h0000, 16'h0000, 16'h0000);  // undefined

    // Reset during T3 of ADD: no T4 word, fetch restarts.
    add(4'h2, 0, 0, 1, 3'd0, 16'h4004, 0);
    add(4'h2, 0, 0, 1, 3'd1, 16'h1408, 0);
    add(4'h2, 0, 0, 1, 3'd2, 16'h4800, 0);
    add(4'h2, 0, 0, 0, 3'd3, 16'h1020, 0);
    add(4'h2, 0, 0, 1, 3'd0, 16'h4004, 0);
    add(4'h2, 0, 0, 1, 3'd1, 16'h1408, 0);
    add(4'h2, 0, 0, 1, 3'd2, 16'h4800, 0);
    add(4'h2, 0, 0, 1, 3'd3, 16'h1020, 0);
    add(4'h2, 0, 0, 1, 3'd4, 16'h0281, 0);

    // HLT, then opcode/flags churn while halted, then reset releases it.
    add(4'hF, 0, 0, 1, 3'd0, 16'h4004, 0);
    add(4'h1, 0, 0, 1, 3'd1, 16'h1408, 0);
    add(4'hF, 0, 0, 1, 3'd2, 16'h8000, 0);
    for (int i = 0; i < 10; i++)
      add(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'b1, 3'd2, 16'h8000, 1'b1);
    add(4'h2, 1, 1, 0, 3'd2, 16'h8000, 1);
    add(4'h5, 0, 0, 1, 3'd0, 16'h4004, 0);
    add(4'h5, 0, 0, 1, 3'd1, 16'h1408, 0);
    add(4'h5, 0, 0, 1, 3'd2, 16'h0A00, 0);
    add(4'h5, 0, 0, 1, 3'd3, 16'h0000, 0);
    add(4'h5, 0, 0, 1, 3'd0, 16'h4004, 0);

    idx = 0;
    while (stim_q.size() > 0) begin
      v = stim_q.pop_front();
      opcode = v.op; flag_c = v.fc; flag_z = v.fz; reset = v.rst;
      e.st = v.st; e.ct = v.ct; e.h = v.h;
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      check($sformatf("c%0d.step", idx),   16'(step),   16'(e.st));
      check($sformatf("c%0d.ctrl", idx),   ctrl,        e.ct);
      check($sformatf("c%0d.halted", idx), 16'(halted), 16'(e.h));
      idx++;
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter: NUM_STEPS, default 5, microsteps per instruction (T0..T4).
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: opcode  input  4  instruction register high nibble, valid from T2 onward.
REQ-005 SHALL have port: flag_c  input  1  carry flag from flags register.
REQ-006 SHALL have port: flag_z  input  1  zero flag from flags register.
REQ-007 SHALL have port: ctrl  output  16  control word driving bus-register in/out/clr strobes.
REQ-008 SHALL have port: step  output  3  current microstep.
REQ-009 SHALL have port: halted  output  1  high while the machine is halted.

Function
REQ-010 ctrl bit map SHALL be: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
REQ-011 ctrl SHALL be combinational from registered step, opcode, flag_c, flag_z and halted; no extra latency.
REQ-012 Fetch, all opcodes: T0 = CO|MI (0x4004); T1 = RO|II|CE (0x1408); opcode ignored in T0/T1.
REQ-013 LDA (0x1): T2 IO|MI (0x4800); T3 RO|AI (0x1200).
REQ-014 ADD (0x2): T2 0x4800; T3 RO|BI (0x1020); T4 EO|AI|FI (0x0281).
REQ-015 SUB (0x3): as ADD, T4 EO|AI|SU|FI (0x02C1).
REQ-016 STA (0x4): T2 0x4800; T3 AO|RI (0x2100).
REQ-017 LDI (0x5): T2 IO|AI (0x0A00).
REQ-018 JMP (0x6): T2 IO|J (0x0802).
REQ-019 JC (0x7): T2 0x0802 when flag_c=1, else 0x0000; JZ (0x8): same using flag_z.
REQ-020 OUT (0xE): T2 AO|OI (0x0110); HLT (0xF): T2 HLT (0x8000).
REQ-021 NOP (0x0) and undefined opcodes 0x9..0xD SHALL produce 0x0000 at T2..T4.
REQ-022 Steps not listed for an opcode SHALL decode to 0x0000.
REQ-023 Step advance: step+1 each edge; from NUM_STEPS-1 wrap to 0.
REQ-024 Early end: at step>=2 with decoded ctrl==0x0000, next step SHALL be 0 (the zero cycle is consumed).
REQ-025 Resulting lengths: NOP 3 cycles, LDI/JMP/OUT 4, LDA/STA 5, ADD/SUB 5 (wrap after T4), untaken JC/JZ 3.
REQ-026 Halt: edge ending T2 of HLT SHALL set halted=1; step then frozen at 2; ctrl held 0x8000.
REQ-027 Once halted, opcode/flag changes SHALL have no effect; only reset clears halted.

Reset
REQ-028 reset=0 at a rising edge SHALL set step=0, halted=0, overriding advance, early end and halt.
REQ-029 Output values during/after reset: step=0, halted=0, ctrl=0x4004.
REQ-030 Reset mid-instruction (any step, including halted) SHALL restart fetch at T0 on the next cycle.

Structure
REQ-031 Shared package sap_ctrl_pkg SHALL hold ctrl bit indices, opcode constants and NUM_STEPS default, shared with datapath registers.
REQ-032 Microcode decode SHALL be a combinational sub-module microcode_rom (step, opcode, flags -> 16-bit word); step counter and halt flag stay in control_sequencer.

Verification
REQ-033 Reset low one edge -> step=0, ctrl=0x4004, halted=0; next edge step=1, ctrl=0x1408.
REQ-034 opcode=0x5 -> step 0,1,2,3,0; ctrl at T2 0x0A00, T3 0x0000.
REQ-035 opcode=0x2 -> T2 0x4800, T3 0x1020, T4 0x0281, then step=0 ctrl=0x4004.
REQ-036 opcode=0x7, flag_c=0 -> T2 ctrl 0x0000, next step 0; repeat with flag_c=1 -> T2 0x0802, T3 0x0000.
REQ-037 opcode=0xF -> T2 0x8000, halted=1 next edge, step=2 and ctrl=0x8000 for 10 cycles while opcode toggles; reset low -> step 0, halted 0.
REQ-038 Reset low during T3 of ADD -> next cycle step=0, ctrl=0x4004, no T4 word emitted.
